fpaddsub_pipe_tracker: RTL

- Downstream control stage for the FP add/sub pipeline input FSM.
- Consumes the pipeline-input enable and the shift enable, tracks valid tokens through the pipeline, and generates per-stage register enables.
- Captures the final-stage result with its exception flags and pulses a result-ready strobe.
- Flags protocol errors: an insertion lost while shifting is disabled, and an excessive stall.

---
 rtl/fpaddsub_pipe_tracker.sv | 119 +++++++++++
 1 files changed

// File: rtl/fpaddsub_pipe_tracker.sv
// rtl/fpaddsub_pipe_tracker.sv - token tracker, stage enables and result capture for the FP add/sub pipeline
// Follows insertions through STAGES registers, captures the last-stage result and flags protocol errors.
module fpaddsub_pipe_tracker #(
    parameter int STAGES  = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_Pipeline_input,
    input  logic              enable_shift_reg,
    input  logic              op_in,
    input  logic [W-1:0]      result_in,
    input  logic              overflow_in,
    input  logic              underflow_in,
    output logic [STAGES-1:0] stage_enable,
    output logic [STAGES-1:0] valid_vec,
    output logic              ready,
    output logic [W-1:0]      result_out,
    output logic              op_out,
    output logic              overflow_flag,
    output logic              underflow_flag,
    output logic              busy,
    output logic              drop_err,
    output logic              stall_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] tag;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] tag_d;
    logic [CW-1:0]     stall_cnt;
    logic [CW-1:0]     stall_cnt_d;
    logic              capture;

    assign capture   = enable_shift_reg & valid[STAGES-1];
    assign valid_vec = valid;
    assign busy      = (state != IDLE) | ready;

    // Enables are held off while reset is asserted so no stage loads garbage.
    assign stage_enable = {valid[STAGES-2:0] & {(STAGES-1){enable_shift_reg}},
                           enable_shift_reg & enable_Pipeline_input} & {STAGES{rst}};

    always_comb begin
        valid_d = valid;
        tag_d   = tag;
        if (enable_shift_reg) begin
            valid_d = {valid[STAGES-2:0], enable_Pipeline_input};
            tag_d   = {tag[STAGES-2:0], op_in};
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (|valid_d) state_d = RUN;
            end
            RUN: begin
                if (!(|valid_d))           state_d = IDLE;
                else if (!enable_shift_reg) state_d = STALL;
            end
            STALL: begin
                if (enable_shift_reg) state_d = (|valid_d) ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts the consecutive cycles that end in STALL, so the count includes the current one.
    always_comb begin
        stall_cnt_d = '0;
        if (state_d == STALL) begin
            stall_cnt_d = (stall_cnt == TMAX) ? stall_cnt : stall_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            valid          <= '0;
            tag            <= '0;
            stall_cnt      <= '0;
            ready          <= 1'b0;
            result_out     <= '0;
            op_out         <= 1'b0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            drop_err       <= 1'b0;
            stall_timeout  <= 1'b0;
        end else begin
            state     <= state_d;
            valid     <= valid_d;
            tag       <= tag_d;
            stall_cnt <= stall_cnt_d;
            ready     <= capture;
            if (capture) begin
                result_out     <= result_in;
                op_out         <= tag[STAGES-1];
                overflow_flag  <= overflow_in;
                underflow_flag <= underflow_in;
            end
            if (enable_Pipeline_input && !enable_shift_reg) drop_err <= 1'b1;
            if (state_d == STALL && stall_cnt_d == TMAX) stall_timeout <= 1'b1;
        end
    end

endmodule
